// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-ALU system: controller state encoding,
// default widths and the ALU opcode set.
package uart_alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 6;

    // Controller states, 3-bit encoding
    localparam logic [2:0] S_A       = 3'd0;
    localparam logic [2:0] S_B       = 3'd1;
    localparam logic [2:0] S_OP      = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_WAIT_TX = 3'd5;

    // ALU opcodes
    localparam logic [5:0] ALU_ADD = 6'h20;
    localparam logic [5:0] ALU_SUB = 6'h22;
    localparam logic [5:0] ALU_AND = 6'h24;
    localparam logic [5:0] ALU_OR  = 6'h25;
    localparam logic [5:0] ALU_XOR = 6'h26;
    localparam logic [5:0] ALU_NOR = 6'h27;
    localparam logic [5:0] ALU_SRA = 6'h03;
    localparam logic [5:0] ALU_SRL = 6'h02;

    // True while a frame is partially received and inter-byte time matters
    function automatic logic in_frame(input logic [2:0] s);
        return (s == S_B) || (s == S_OP);
    endfunction

endpackage

// File: rtl/uart_alu_intf_ctrl_timeout_counter.sv
// Inter-byte timeout counter: counts enabled s_tick pulses and flags the
// pulse that would reach TICKS. Only built with UART_ALU_INTF_TIMEOUT_EN.
`ifdef UART_ALU_INTF_TIMEOUT_EN
module intf_timeout_counter #(
    parameter int unsigned TICKS = 49152,
    parameter int          W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(TICKS - 1);

    logic [W-1:0] count;

    // tc marks the tick that would make the count equal TICKS
    assign tc = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr || tc) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule
`endif

// File: rtl/uart_alu_intf_ctrl.sv
// Sequencer between UART RX, ALU and UART TX: collects A, B, opcode, drives
// the ALU and sends one result byte. Optional timeout: UART_ALU_INTF_TIMEOUT_EN.
module uart_alu_intf_ctrl
    import uart_alu_pkg::*;
#(
    parameter int          DATA_W        = DATA_W_DEF,
    parameter int          OP_W          = OP_W_DEF,
    parameter int unsigned TIMEOUT_TICKS = 49152,
    parameter int          TO_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tick,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done_tick,
    input  logic              tx_done_tick,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    output logic              overrun,
    output logic              timeout_tick
);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       timeout_hit;
    logic       load_a;
    logic       load_b;
    logic       load_op;
    logic       drop;

`ifdef UART_ALU_INTF_TIMEOUT_EN
    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;
    logic timeout_q;

    assign cnt_en  = s_tick && in_frame(state);
    assign cnt_clr = rx_done_tick || !in_frame(state);

    intf_timeout_counter #(
        .TICKS (TIMEOUT_TICKS),
        .W     (TO_W)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // A byte arriving together with the expiring tick keeps the frame alive
    assign timeout_hit = cnt_tc && !rx_done_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
        end
    end

    assign timeout_tick = timeout_q;
`else
    logic unused_cfg;

    assign unused_cfg   = s_tick ^ TIMEOUT_TICKS[0] ^ TO_W[0];
    assign timeout_hit  = 1'b0;
    assign timeout_tick = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_A: begin
                if (rx_done_tick) state_next = S_B;
            end
            S_B: begin
                if (rx_done_tick)     state_next = S_OP;
                else if (timeout_hit) state_next = S_A;
            end
            S_OP: begin
                if (rx_done_tick)     state_next = S_EXEC;
                else if (timeout_hit) state_next = S_A;
            end
            S_EXEC:  state_next = S_SEND;
            S_SEND:  state_next = S_WAIT_TX;
            S_WAIT_TX: begin
                // A byte landing with tx_done is operand A of the next frame
                if (tx_done_tick) state_next = rx_done_tick ? S_B : S_A;
            end
            default: state_next = S_A;
        endcase
    end

    assign load_a  = rx_done_tick &&
                     ((state == S_A) || ((state == S_WAIT_TX) && tx_done_tick));
    assign load_b  = rx_done_tick && (state == S_B);
    assign load_op = rx_done_tick && (state == S_OP);
    assign drop    = rx_done_tick &&
                     ((state == S_EXEC) || (state == S_SEND) ||
                      ((state == S_WAIT_TX) && !tx_done_tick));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_A;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            tx_data <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_next;
            if (load_a)  alu_a  <= rx_data;
            if (load_b)  alu_b  <= rx_data;
            if (load_op) alu_op <= rx_data[OP_W-1:0];
            if (state == S_EXEC) tx_data <= alu_result;
            if (drop) overrun <= 1'b1;
        end
    end

    // Decoded from the state register so the pulse lines up with S_SEND
    assign tx_start = (state == S_SEND);

endmodule

// File: tb/tb_uart_alu_intf_ctrl.sv
// Directed and random frames through uart_alu_intf_ctrl with a scoreboard of
// expected transmit bytes; covers the UART_ALU_INTF_TIMEOUT_EN build too.
module tb_uart_alu_intf_ctrl;
    import uart_alu_pkg::*;

    localparam int unsigned TB_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       tx_done_tick;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       overrun;
    logic       timeout_tick;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_op_cyc = 0;
    int tx_count = 0;
    int to_count = 0;
    int frames_sent = 0;
    logic prev_tx_start = 1'b0;
    logic [7:0] exp_q[$];

    uart_alu_intf_ctrl #(
        .DATA_W        (8),
        .OP_W          (6),
        .TIMEOUT_TICKS (TB_TIMEOUT),
        .TO_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .tx_done_tick (tx_done_tick),
        .alu_result   (alu_result),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .overrun      (overrun),
        .timeout_tick (timeout_tick)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference ALU ----------------
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h03: return 8'($signed(a) >>> b[2:0]);
            6'h02: return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_a, alu_b, alu_op);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every tx_start pops one expected byte
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_start) begin
                tx_count++;
                check("tx_start_single", {31'b0, prev_tx_start}, 32'd0);
                check("tx_latency", cyc - last_op_cyc, 32'd2);
                check("exp_q_nonempty", {31'b0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) check("tx_data", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
            end
            if (timeout_tick) to_count++;
        end
        prev_tx_start = tx_start;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] op, input int gap);
        send_byte(a);
        idle(gap);
        send_byte(b);
        idle(gap);
        exp_q.push_back(alu_model(a, b, op[5:0]));
        frames_sent++;
        last_op_cyc = cyc;
        send_byte(op);
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (dut.state !== s && n < 50) begin
            step();
            n++;
        end
        check(tag, {29'b0, dut.state}, {29'b0, s});
    endtask

    task automatic finish_tx(input int delay, input string tag);
        wait_state(S_WAIT_TX, {tag, "_wait_tx"});
        idle(delay);
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        check({tag, "_back_to_a"}, {29'b0, dut.state}, {29'b0, S_A});
    endtask

    task automatic s_pulse();
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
        step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_state"}, {29'b0, dut.state}, {29'b0, S_A});
        check({tag, "_alu_a"}, {24'b0, alu_a}, 32'h0);
        check({tag, "_alu_b"}, {24'b0, alu_b}, 32'h0);
        check({tag, "_alu_op"}, {26'b0, alu_op}, 32'h0);
        check({tag, "_tx_data"}, {24'b0, tx_data}, 32'h0);
        check({tag, "_tx_start"}, {31'b0, tx_start}, 32'h0);
        check({tag, "_overrun"}, {31'b0, overrun}, 32'h0);
        check({tag, "_timeout"}, {31'b0, timeout_tick}, 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int tx_before;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [5:0] ops[8];

        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
        reset = 1'b1;
        s_tick = 1'b0;
        rx_data = 8'h00;
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        idle(3);
        check_cleared("reset");
        reset = 1'b0;

        // Basic ADD frame with wide gaps
        tx_before = tx_count;
        send_frame(8'h05, 8'h03, 8'h20, 200);
        check("add_alu_a", {24'b0, alu_a}, 32'h05);
        check("add_alu_b", {24'b0, alu_b}, 32'h03);
        check("add_alu_op", {26'b0, alu_op}, 32'h20);
        finish_tx(5, "add");
        check("add_one_tx", tx_count - tx_before, 32'd1);
        check("add_tx_data_hold", {24'b0, tx_data}, 32'h08);

        // Byte dropped while waiting for the transmitter
        send_frame(8'h07, 8'h02, 8'h22, 1);
        wait_state(S_WAIT_TX, "ovr_wait");
        send_byte(8'h99);
        check("ovr_set", {31'b0, overrun}, 32'd1);
        check("ovr_alu_a_kept", {24'b0, alu_a}, 32'h07);
        check("ovr_state", {29'b0, dut.state}, {29'b0, S_WAIT_TX});
        finish_tx(2, "ovr");
        send_frame(8'h01, 8'h01, 8'h20, 0);
        finish_tx(3, "ovr_next");
        check("ovr_sticky", {31'b0, overrun}, 32'd1);

        // tx_done and rx_done together: byte becomes operand A
        pulse_reset();
        check("rst2_overrun", {31'b0, overrun}, 32'd0);
        send_frame(8'h0C, 8'h0A, 8'h25, 2);
        wait_state(S_WAIT_TX, "both_wait");
        rx_data = 8'hAA;
        rx_done_tick = 1'b1;
        tx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        check("both_alu_a", {24'b0, alu_a}, 32'hAA);
        check("both_state", {29'b0, dut.state}, {29'b0, S_B});
        check("both_overrun", {31'b0, overrun}, 32'd0);
        send_byte(8'h11);
        exp_q.push_back(8'hAA & 8'h11);
        frames_sent++;
        last_op_cyc = cyc;
        send_byte(8'h24);
        finish_tx(1, "both");

        // Reset in S_OP discards the partial frame
        send_byte(8'h40);
        send_byte(8'h50);
        check("prerst_state", {29'b0, dut.state}, {29'b0, S_OP});
        tx_before = tx_count;
        pulse_reset();
        check_cleared("midrst");
        idle(10);
        check("midrst_no_tx", tx_count - tx_before, 32'd0);
        send_frame(8'h10, 8'h01, 8'h22, 3);
        finish_tx(4, "fresh");
        check("fresh_one_tx", tx_count - tx_before, 32'd1);

`ifdef UART_ALU_INTF_TIMEOUT_EN
        // Expiry on the 8th tick, then a byte racing the 8th tick
        send_byte(8'h44);
        for (int i = 0; i < 7; i++) s_pulse();
        check("to_not_yet", {29'b0, dut.state}, {29'b0, S_B});
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
        check("to_pulse", {31'b0, timeout_tick}, 32'd1);
        check("to_state", {29'b0, dut.state}, {29'b0, S_A});
        check("to_alu_a_kept", {24'b0, alu_a}, 32'h44);
        step();
        check("to_pulse_end", {31'b0, timeout_tick}, 32'd0);
        check("to_count", to_count, 32'd1);
        send_byte(8'h55);
        for (int i = 0; i < 7; i++) s_pulse();
        rx_data = 8'h33;
        rx_done_tick = 1'b1;
        s_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        s_tick = 1'b0;
        check("race_state", {29'b0, dut.state}, {29'b0, S_OP});
        check("race_alu_b", {24'b0, alu_b}, 32'h33);
        step();
        check("race_no_pulse", {31'b0, timeout_tick}, 32'd0);
        exp_q.push_back(8'h55 + 8'h33);
        frames_sent++;
        last_op_cyc = cyc;
        send_byte(8'h20);
        finish_tx(2, "race");
        check("race_to_count", to_count, 32'd1);
`else
        // Without the timeout a partial frame waits indefinitely
        send_byte(8'h44);
        for (int i = 0; i < 20; i++) s_pulse();
        check("noto_state", {29'b0, dut.state}, {29'b0, S_B});
        check("noto_count", to_count, 32'd0);
        send_byte(8'h02);
        exp_q.push_back(8'h44 >> 2);
        frames_sent++;
        last_op_cyc = cyc;
        send_byte(8'h02);
        finish_tx(1, "noto");
`endif

        // Back-to-back random frames
        tx_before = tx_count;
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send_frame(ra, rb, {2'b00, ops[$urandom_range(0, 7)]}, $urandom_range(0, 3));
            finish_tx($urandom_range(0, 6), "rnd");
        end
        check("rnd_tx_count", tx_count - tx_before, 32'd10);
        check("rnd_overrun", {31'b0, overrun}, 32'd0);

        idle(3);
        check("total_tx", tx_count, frames_sent);
        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
